lc3b_load_scoreboard: RTL and testbench

Parametrised load-use hazard unit for the LC-3b pipeline, sitting beside the IF/ID and ID/EX registers. It replaces single-stage ID/EX load comparison with a per-register scoreboard of in-flight loads, so variable-latency memory (cache misses, multi-cycle responses) is handled without stage-position assumptions. It drives the PC/IF_ID load enables and the ID/EX bubble, and provides a WB-bypass mode, capacity stalls, a stall-cycle counter and an error flag.

---
 rtl/lc3b_load_scoreboard.sv | 154 +++++++++++++++
 tb/tb_lc3b_load_scoreboard.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/lc3b_load_scoreboard.sv
// lc3b_load_scoreboard
//
// Load-use hazard unit for the LC-3b pipeline. It sits beside IF/ID and
// ID/EX and keeps a per-register count of loads that have issued but not
// yet written back. A consumer in ID stalls while any of its sources has a
// load outstanding, whatever the memory latency. A load in ID also stalls
// when the scoreboard has no room for it.
//
// Ports
//   clk, reset      rising-edge clock, asynchronous active-high reset
//   id_valid        ID holds a real instruction
//   id_opcode       LC-3b opcode in ID
//   id_bit5         IR[5] (ADD/AND immediate select)
//   id_bit11        IR[11] (JSR vs JSRR)
//   id_sr1, id_sr2  source fields; a store's data register arrives on id_sr2
//   id_dest         destination field
//   id_is_load      LDB/LDI/LDR in ID
//   flush           kill the ID instruction this cycle
//   wb_load_valid   a load result is written to the regfile this cycle
//   wb_load_dest    destination of that load
//   forward_load    PC / IF_ID load enable (= !hazard)
//   hazard          insert a bubble into ID/EX
//   inflight        number of outstanding loads
//   stall_cycles    saturating count of hazard cycles
//   sb_error        sticky: a load retired with nothing pending
module lc3b_load_scoreboard #(
  parameter int NUM_REGS     = 8,
  parameter int REG_W        = 3,
  parameter int CNT_W        = 2,
  parameter int MAX_INFLIGHT = 4,
  parameter int WB_BYPASS    = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [3:0]       id_opcode,
  input  logic             id_bit5,
  input  logic             id_bit11,
  input  logic [REG_W-1:0] id_sr1,
  input  logic [REG_W-1:0] id_sr2,
  input  logic [REG_W-1:0] id_dest,
  input  logic             id_is_load,
  input  logic             flush,
  input  logic             wb_load_valid,
  input  logic [REG_W-1:0] wb_load_dest,
  output logic             forward_load,
  output logic             hazard,
  output logic [3:0]       inflight,
  output logic [15:0]      stall_cycles,
  output logic             sb_error
);

  localparam logic [3:0] OP_BR   = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_STB  = 4'h3;
  localparam logic [3:0] OP_JSR  = 4'h4;
  localparam logic [3:0] OP_AND  = 4'h5;
  localparam logic [3:0] OP_STW  = 4'h7;
  localparam logic [3:0] OP_STI  = 4'hB;
  localparam logic [3:0] OP_LEA  = 4'hE;
  localparam logic [3:0] OP_TRAP = 4'hF;

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [3:0]       MAX_INF  = 4'(MAX_INFLIGHT);
  localparam logic             BYPASS   = (WB_BYPASS != 0);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [NUM_REGS-1:0][CNT_W-1:0] cnt;

  // Register fields are decoded one-hot against the tracked registers, so an
  // index >= NUM_REGS matches nothing: never pending, never allocated.
  logic [NUM_REGS-1:0] hit_sr1, hit_sr2, hit_dest, hit_wb, pend_eff;
  logic [CNT_W-1:0]    dest_cnt, wb_cnt, dest_cnt_free;
  logic [3:0]          inflight_free;
  logic                sr1_used, sr2_used, src_hazard, cap_hazard;
  logic                retire, err_set, alloc, dest_tracked;

  always_comb begin
    hit_sr1  = '0;
    hit_sr2  = '0;
    hit_dest = '0;
    hit_wb   = '0;
    pend_eff = '0;
    dest_cnt = '0;
    wb_cnt   = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      hit_sr1[i]  = (id_sr1 == REG_W'(i));
      hit_sr2[i]  = (id_sr2 == REG_W'(i));
      hit_dest[i] = (id_dest == REG_W'(i));
      hit_wb[i]   = (wb_load_dest == REG_W'(i));
      if (hit_dest[i]) dest_cnt = cnt[i];
      if (hit_wb[i])   wb_cnt   = cnt[i];
      // The last pending load for a register being written back this cycle
      // can be picked up from the WB bypass, so it no longer blocks a reader.
      pend_eff[i] = (cnt[i] != '0) &&
                    !(BYPASS && wb_load_valid && hit_wb[i] && cnt[i] == CNT_ONE);
    end
    dest_tracked = |hit_dest;

    sr1_used = !((id_opcode == OP_BR) || (id_opcode == OP_LEA) ||
                 (id_opcode == OP_JSR && id_bit11) || (id_opcode == OP_TRAP));
    sr2_used = ((id_opcode == OP_ADD || id_opcode == OP_AND) && !id_bit5) ||
               (id_opcode == OP_STB) || (id_opcode == OP_STW) ||
               (id_opcode == OP_STI);

    retire  = wb_load_valid && (wb_cnt != '0);
    err_set = wb_load_valid && (wb_cnt == '0);

    // A retire this cycle frees its slot before the capacity check.
    inflight_free = inflight - {3'b000, retire};
    dest_cnt_free = dest_cnt -
                    CNT_W'(retire && (wb_load_dest == id_dest));

    src_hazard = (sr1_used && |(hit_sr1 & pend_eff)) ||
                 (sr2_used && |(hit_sr2 & pend_eff));
    cap_hazard = id_is_load &&
                 ((inflight_free == MAX_INF) || (dest_cnt_free == CNT_MAX));

    hazard       = !reset && id_valid && !flush && (src_hazard || cap_hazard);
    forward_load = !hazard;
    alloc        = !reset && id_valid && !flush && !hazard && id_is_load &&
                   dest_tracked;
  end

  // State update boundary: scoreboard counts, in-flight total, statistics.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt          <= '0;
      inflight     <= '0;
      stall_cycles <= '0;
      sb_error     <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        case ({alloc && hit_dest[i], retire && hit_wb[i]})
          2'b10:   cnt[i] <= cnt[i] + CNT_ONE;
          2'b01:   cnt[i] <= cnt[i] - CNT_ONE;
          default: cnt[i] <= cnt[i];
        endcase
      end
      case ({alloc, retire})
        2'b10:   inflight <= inflight + 4'd1;
        2'b01:   inflight <= inflight - 4'd1;
        default: inflight <= inflight;
      endcase
      if (hazard) stall_cycles <= sat_inc16(stall_cycles);
      if (err_set) sb_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lc3b_load_scoreboard.sv
module tb_lc3b_load_scoreboard;

  localparam logic [3:0] BR = 4'h0, ADD = 4'h1, STB = 4'h3, JSR = 4'h4,
                         LDR = 4'h6, STW = 4'h7, LEA = 4'hE, TRAP = 4'hF;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       id_valid = 0, id_bit5 = 0, id_bit11 = 0, id_is_load = 0;
  logic       flush = 0, wb_load_valid = 0;
  logic [3:0] id_opcode = 0;
  logic [2:0] id_sr1 = 0, id_sr2 = 0, id_dest = 0, wb_load_dest = 0;

  logic        fwd_a, haz_a, err_a, fwd_b, haz_b, err_b;
  logic [3:0]  inf_a, inf_b;
  logic [15:0] st_a, st_b;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lc3b_load_scoreboard #(.WB_BYPASS(1)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_bit5(id_bit5), .id_bit11(id_bit11), .id_sr1(id_sr1), .id_sr2(id_sr2),
    .id_dest(id_dest), .id_is_load(id_is_load), .flush(flush),
    .wb_load_valid(wb_load_valid), .wb_load_dest(wb_load_dest),
    .forward_load(fwd_a), .hazard(haz_a), .inflight(inf_a),
    .stall_cycles(st_a), .sb_error(err_a));

  lc3b_load_scoreboard #(.WB_BYPASS(0)) dut_nb (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_bit5(id_bit5), .id_bit11(id_bit11), .id_sr1(id_sr1), .id_sr2(id_sr2),
    .id_dest(id_dest), .id_is_load(id_is_load), .flush(flush),
    .wb_load_valid(wb_load_valid), .wb_load_dest(wb_load_dest),
    .forward_load(fwd_b), .hazard(haz_b), .inflight(inf_b),
    .stall_cycles(st_b), .sb_error(err_b));

  typedef struct {
    logic       v;
    logic [3:0] op;
    logic       b5, b11;
    logic [2:0] s1, s2, d;
    logic       ld, fl, wv;
    logic [2:0] wd;
    logic       haz;
    logic [3:0] inf;
    logic [15:0] st;
    logic       err;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic v, input logic [3:0] op,
                              input logic b5, input logic b11,
                              input logic [2:0] s1, input logic [2:0] s2,
                              input logic [2:0] d, input logic ld,
                              input logic fl, input logic wv,
                              input logic [2:0] wd, input logic haz,
                              input logic [3:0] inf, input logic [15:0] st,
                              input logic err);
    vec_t r;
    r.v = v; r.op = op; r.b5 = b5; r.b11 = b11; r.s1 = s1; r.s2 = s2;
    r.d = d; r.ld = ld; r.fl = fl; r.wv = wv; r.wd = wd;
    r.haz = haz; r.inf = inf; r.st = st; r.err = err;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t x);
    id_valid = x.v; id_opcode = x.op; id_bit5 = x.b5; id_bit11 = x.b11;
    id_sr1 = x.s1; id_sr2 = x.s2; id_dest = x.d; id_is_load = x.ld;
    flush = x.fl; wb_load_valid = x.wv; wb_load_dest = x.wd;
  endtask

  task automatic idle();
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    reset = 1'b1;
    #2;
    chk("rst_haz", haz_a, 0);
    chk("rst_fwd", fwd_a, 1);
    chk("rst_inf", inf_a, 0);
    chk("rst_stall", st_a, 0);
    chk("rst_err", err_a, 0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    vec_t add_r3;
    do_reset();

    // Load-use: LDR R2, then ADD R3,R2,R1 held in ID; R2 retires on the
    // third ADD cycle.
    @(negedge clk);
    drive(mk(1, LDR, 0, 0, 1, 0, 2, 1, 0, 0, 0, 0, 0, 0, 0));
    #3 chk("lu_ldr_haz", haz_a, 0);
    @(posedge clk); #1 chk("lu_inf1", inf_a, 1);
    add_r3 = mk(1, ADD, 0, 0, 2, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      add_r3.wv = (c == 2);
      add_r3.wd = 3'd2;
      drive(add_r3);
      #3;
      chk($sformatf("lu_byp_c%0d", c), haz_a, (c < 2) ? 1 : 0);
      chk($sformatf("lu_nob_c%0d", c), haz_b, (c < 3) ? 1 : 0);
      chk($sformatf("lu_fwd_c%0d", c), fwd_b, (c < 3) ? 0 : 1);
    end
    @(posedge clk); #1;
    chk("lu_inf_byp", inf_a, 0);
    chk("lu_inf_nob", inf_b, 0);
    chk("lu_st_byp", st_a, 2);
    chk("lu_st_nob", st_b, 3);

    do_reset();

    // Source usage by opcode
    tbl.push_back(mk(1, LDR, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, BR,  0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, LEA, 0, 0, 2, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, TRAP,0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, JSR, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, JSR, 0, 0, 2, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0));
    tbl.push_back(mk(1, ADD, 1, 0, 0, 2, 3, 0, 0, 0, 0, 0, 1, 1, 0));
    tbl.push_back(mk(1, STW, 0, 0, 0, 2, 0, 0, 0, 0, 0, 1, 1, 2, 0));
    tbl.push_back(mk(1, STB, 0, 0, 0, 2, 0, 0, 0, 0, 0, 1, 1, 3, 0));
    tbl.push_back(mk(1, LDR, 0, 0, 2, 0, 3, 1, 0, 0, 0, 1, 1, 4, 0));
    tbl.push_back(mk(0, 0,   0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 4, 0));
    // In-flight capacity
    for (int r = 1; r <= 4; r++)
      tbl.push_back(mk(1, LDR, 0, 0, 0, 0, 3'(r), 1, 0, 0, 0, 0, 4'(r), 4, 0));
    tbl.push_back(mk(1, LDR, 0, 0, 0, 0, 5, 1, 0, 0, 0, 1, 4, 5, 0));
    tbl.push_back(mk(1, LDR, 0, 0, 0, 0, 5, 1, 0, 1, 1, 0, 4, 5, 0));
    tbl.push_back(mk(0, 0,   0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 3, 5, 0));
    tbl.push_back(mk(0, 0,   0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 2, 5, 0));
    tbl.push_back(mk(0, 0,   0, 0, 0, 0, 0, 0, 0, 1, 4, 0, 1, 5, 0));
    // Per-register count capacity on R5
    tbl.push_back(mk(1, LDR, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 2, 5, 0));
    tbl.push_back(mk(1, LDR, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 3, 5, 0));
    tbl.push_back(mk(1, LDR, 0, 0, 0, 0, 5, 1, 0, 0, 0, 1, 3, 6, 0));
    tbl.push_back(mk(1, ADD, 0, 0, 5, 0, 0, 0, 0, 1, 5, 1, 2, 7, 0));
    tbl.push_back(mk(1, ADD, 0, 0, 5, 0, 0, 0, 0, 1, 5, 1, 1, 8, 0));
    tbl.push_back(mk(1, ADD, 0, 0, 5, 0, 0, 0, 0, 1, 5, 0, 0, 8, 0));
    tbl.push_back(mk(1, ADD, 0, 0, 5, 0, 0, 0, 0, 0, 0, 0, 0, 8, 0));
    // Spurious retire, then alloc+retire on R4 in one cycle
    tbl.push_back(mk(0, 0,   0, 0, 0, 0, 0, 0, 0, 1, 6, 0, 0, 8, 1));
    tbl.push_back(mk(0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8, 1));
    tbl.push_back(mk(1, LDR, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0, 1, 8, 1));
    tbl.push_back(mk(1, LDR, 0, 0, 0, 0, 4, 1, 0, 1, 4, 0, 1, 8, 1));
    tbl.push_back(mk(1, ADD, 1, 0, 4, 0, 0, 0, 0, 0, 0, 1, 1, 9, 1));
    tbl.push_back(mk(0, 0,   0, 0, 0, 0, 0, 0, 0, 1, 4, 0, 0, 9, 1));
    tbl.push_back(mk(1, ADD, 1, 0, 4, 0, 0, 0, 0, 0, 0, 0, 0, 9, 1));
    // Flush
    tbl.push_back(mk(1, LDR, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0, 1, 9, 1));
    tbl.push_back(mk(1, ADD, 1, 0, 2, 0, 0, 0, 1, 0, 0, 0, 1, 9, 1));
    tbl.push_back(mk(1, LDR, 0, 0, 0, 0, 3, 1, 1, 0, 0, 0, 1, 9, 1));
    tbl.push_back(mk(0, 0,   0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 9, 1));

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i]);
      #3;
      chk($sformatf("v%0d_haz", i), haz_a, tbl[i].haz);
      chk($sformatf("v%0d_fwd", i), fwd_a, !tbl[i].haz);
      @(posedge clk); #1;
      chk($sformatf("v%0d_inf", i), inf_a, tbl[i].inf);
      chk($sformatf("v%0d_stall", i), st_a, tbl[i].st);
      chk($sformatf("v%0d_err", i), err_a, tbl[i].err);
    end

    // Asynchronous reset in the middle of a stall
    @(negedge clk);
    drive(mk(1, LDR, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    drive(mk(1, ADD, 1, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #2 chk("mid_haz_before", haz_a, 1);
    reset = 1'b1;
    #1;
    chk("mid_haz", haz_a, 0);
    chk("mid_fwd", fwd_a, 1);
    chk("mid_inf", inf_a, 0);
    chk("mid_stall", st_a, 0);
    chk("mid_err", err_a, 0);
    @(posedge clk); #1;
    chk("mid_hold_stall", st_a, 0);
    chk("mid_hold_inf", inf_a, 0);
    @(negedge clk);
    reset = 1'b0;
    #3 chk("mid_forgotten", haz_a, 0);
    @(posedge clk); #1 chk("mid_after_stall", st_a, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
